// File: rtl/mxu_cmd_seq.sv
// mxu_cmd_seq: sequencer between the LSU command path and the MXU top.
//
// Accepts one matrix command at a time. Optionally clears the MXU, then streams
// up to 16 input rows and 16 weight rows from the local row buffer into the MXU.
// It then fires the MXU with the pool/activation config, waits for result-ready
// and reports completion (done) or failure (err).
//
// Ports:
//   clk, rst                synchronous active-high reset
//   cmd_*                   command handshake and fields (captured on cmd_vld && cmd_rdy)
//   buf_rd_en/addr/data     row-buffer read port, data valid one cycle after buf_rd_en
//   lsu_top_*               all control/payload inputs of the MXU top
//   top_lsu_rdy             MXU can accept clr/row/fire this cycle
//   top_lsu_data_rdy        MXU result rows valid
//   busy, done, err         status; done/err are single-cycle pulses
module mxu_cmd_seq #(
    parameter int unsigned AW      = 10,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          cmd_vld,
    output logic          cmd_rdy,
    input  logic [4:0]    cmd_rows,
    input  logic          cmd_clr,
    input  logic [AW-1:0] cmd_iaddr,
    input  logic [AW-1:0] cmd_waddr,
    input  logic          cmd_pool_vld,
    input  logic [1:0]    cmd_pool_size,
    input  logic          cmd_act_vld,
    input  logic [1:0]    cmd_act_type,

    output logic          buf_rd_en,
    output logic [AW-1:0] buf_rd_addr,
    input  logic [127:0]  buf_rd_data,

    output logic          lsu_top_vld,
    output logic          lsu_top_clr,
    output logic [15:0]   lsu_top_iram_vld,
    output logic [127:0]  lsu_top_iram_pld,
    output logic [15:0]   lsu_top_wram_vld,
    output logic [127:0]  lsu_top_wram_pld,
    output logic          lsu_top_pool_vld,
    output logic [1:0]    lsu_top_pool_size,
    output logic          lsu_top_act_vld,
    output logic [1:0]    lsu_top_act_type,
    output logic          lsu_top_wfi,
    input  logic          top_lsu_rdy,
    input  logic          top_lsu_data_rdy,

    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StBad,
        StClr,
        StLoad,
        StFire,
        StWait,
        StTmo,
        StDone
    } state_e;

    state_e          state_q, state_d;

    // Registered command fields.
    logic [4:0]      rows_q;
    logic [AW-1:0]   iaddr_q;
    logic [AW-1:0]   waddr_q;
    logic            pool_vld_q;
    logic [1:0]      pool_size_q;
    logic            act_vld_q;
    logic [1:0]      act_type_q;

    // Read index over 2N reads: bit 0 selects input/weight, bits [4:1] are the row.
    logic [5:0]      rd_idx_q, rd_idx_d;

    // Write-back stage tracking the read issued in the previous cycle.
    logic            wb_vld_q;
    logic            wb_wgt_q;
    logic [3:0]      wb_row_q;

    logic [TW-1:0]   tmo_q, tmo_d;

    logic            cmd_accept;
    logic [4:0]      rows_sat;
    logic [3:0]      rd_row;
    logic [AW-1:0]   rd_base;
    logic            last_wb;

    assign cmd_accept = cmd_vld && (state_q == StIdle);
    assign rows_sat   = (cmd_rows > 5'd16) ? 5'd16 : cmd_rows;
    assign rd_row     = rd_idx_q[4:1];
    assign rd_base    = rd_idx_q[0] ? waddr_q : iaddr_q;
    // The final weight write of row N-1 marks the end of LOAD.
    assign last_wb    = wb_vld_q && wb_wgt_q && ({1'b0, wb_row_q} == (rows_q - 5'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rows_q      <= '0;
            iaddr_q     <= '0;
            waddr_q     <= '0;
            pool_vld_q  <= 1'b0;
            pool_size_q <= '0;
            act_vld_q   <= 1'b0;
            act_type_q  <= '0;
            rd_idx_q    <= '0;
            wb_vld_q    <= 1'b0;
            wb_wgt_q    <= 1'b0;
            wb_row_q    <= '0;
            tmo_q       <= '0;
        end else begin
            state_q  <= state_d;
            rd_idx_q <= rd_idx_d;
            tmo_q    <= tmo_d;
            wb_vld_q <= buf_rd_en;
            wb_wgt_q <= rd_idx_q[0];
            wb_row_q <= rd_row;
            if (cmd_accept) begin
                rows_q      <= rows_sat;
                iaddr_q     <= cmd_iaddr;
                waddr_q     <= cmd_waddr;
                pool_vld_q  <= cmd_pool_vld;
                pool_size_q <= cmd_pool_size;
                act_vld_q   <= cmd_act_vld;
                act_type_q  <= cmd_act_type;
            end
        end
    end

    always_comb begin
        state_d           = state_q;
        rd_idx_d          = rd_idx_q;
        tmo_d             = tmo_q;
        cmd_rdy           = 1'b0;
        buf_rd_en         = 1'b0;
        buf_rd_addr       = '0;
        lsu_top_vld       = 1'b0;
        lsu_top_clr       = 1'b0;
        lsu_top_pool_vld  = 1'b0;
        lsu_top_pool_size = '0;
        lsu_top_act_vld   = 1'b0;
        lsu_top_act_type  = '0;
        lsu_top_wfi       = 1'b0;
        done              = 1'b0;
        err               = 1'b0;

        unique case (state_q)
            StIdle: begin
                cmd_rdy  = 1'b1;
                rd_idx_d = '0;
                if (cmd_vld) begin
                    if (cmd_rows == 5'd0) begin
                        state_d = StBad;
                    end else if (cmd_clr) begin
                        state_d = StClr;
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StBad: begin
                err     = 1'b1;
                state_d = StIdle;
            end
            StClr: begin
                if (top_lsu_rdy) begin
                    lsu_top_clr = 1'b1;
                    state_d     = StLoad;
                end
            end
            StLoad: begin
                if (top_lsu_rdy && (rd_idx_q < {rows_q, 1'b0})) begin
                    buf_rd_en   = 1'b1;
                    buf_rd_addr = rd_base + AW'(rd_row);
                    rd_idx_d    = rd_idx_q + 6'd1;
                end
                if (last_wb) begin
                    state_d = StFire;
                end
            end
            StFire: begin
                if (top_lsu_rdy) begin
                    lsu_top_vld       = 1'b1;
                    lsu_top_pool_vld  = pool_vld_q;
                    lsu_top_pool_size = pool_size_q;
                    lsu_top_act_vld   = act_vld_q;
                    lsu_top_act_type  = act_type_q;
                    tmo_d             = '0;
                    state_d           = StWait;
                end
            end
            StWait: begin
                lsu_top_wfi = 1'b1;
                if (top_lsu_data_rdy) begin
                    state_d = StDone;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = StTmo;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            StTmo: begin
                // Clear the MXU so a half-finished result cannot leak into the next command.
                err         = 1'b1;
                lsu_top_clr = 1'b1;
                state_d     = StIdle;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Write-back of the previous cycle's read; independent of top_lsu_rdy.
    always_comb begin
        lsu_top_iram_vld = '0;
        lsu_top_iram_pld = '0;
        lsu_top_wram_vld = '0;
        lsu_top_wram_pld = '0;
        if (wb_vld_q) begin
            if (wb_wgt_q) begin
                lsu_top_wram_vld = 16'd1 << wb_row_q;
                lsu_top_wram_pld = buf_rd_data;
            end else begin
                lsu_top_iram_vld = 16'd1 << wb_row_q;
                lsu_top_iram_pld = buf_rd_data;
            end
        end
    end

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_mxu_cmd_seq.sv
module tb_mxu_cmd_seq;

    localparam int AW      = 10;
    localparam int TIMEOUT = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_vld = 1'b0;
    logic          cmd_rdy;
    logic [4:0]    cmd_rows = '0;
    logic          cmd_clr = 1'b0;
    logic [AW-1:0] cmd_iaddr = '0;
    logic [AW-1:0] cmd_waddr = '0;
    logic          cmd_pool_vld = 1'b0;
    logic [1:0]    cmd_pool_size = '0;
    logic          cmd_act_vld = 1'b0;
    logic [1:0]    cmd_act_type = '0;
    logic          buf_rd_en;
    logic [AW-1:0] buf_rd_addr;
    logic [127:0]  buf_rd_data = '0;
    logic          lsu_top_vld, lsu_top_clr;
    logic [15:0]   lsu_top_iram_vld, lsu_top_wram_vld;
    logic [127:0]  lsu_top_iram_pld, lsu_top_wram_pld;
    logic          lsu_top_pool_vld, lsu_top_act_vld, lsu_top_wfi;
    logic [1:0]    lsu_top_pool_size, lsu_top_act_type;
    logic          top_lsu_rdy = 1'b1;
    logic          top_lsu_data_rdy = 1'b0;
    logic          busy, done, err;

    mxu_cmd_seq #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk               (clk),
        .rst               (rst),
        .cmd_vld           (cmd_vld),
        .cmd_rdy           (cmd_rdy),
        .cmd_rows          (cmd_rows),
        .cmd_clr           (cmd_clr),
        .cmd_iaddr         (cmd_iaddr),
        .cmd_waddr         (cmd_waddr),
        .cmd_pool_vld      (cmd_pool_vld),
        .cmd_pool_size     (cmd_pool_size),
        .cmd_act_vld       (cmd_act_vld),
        .cmd_act_type      (cmd_act_type),
        .buf_rd_en         (buf_rd_en),
        .buf_rd_addr       (buf_rd_addr),
        .buf_rd_data       (buf_rd_data),
        .lsu_top_vld       (lsu_top_vld),
        .lsu_top_clr       (lsu_top_clr),
        .lsu_top_iram_vld  (lsu_top_iram_vld),
        .lsu_top_iram_pld  (lsu_top_iram_pld),
        .lsu_top_wram_vld  (lsu_top_wram_vld),
        .lsu_top_wram_pld  (lsu_top_wram_pld),
        .lsu_top_pool_vld  (lsu_top_pool_vld),
        .lsu_top_pool_size (lsu_top_pool_size),
        .lsu_top_act_vld   (lsu_top_act_vld),
        .lsu_top_act_type  (lsu_top_act_type),
        .lsu_top_wfi       (lsu_top_wfi),
        .top_lsu_rdy       (top_lsu_rdy),
        .top_lsu_data_rdy  (top_lsu_data_rdy),
        .busy              (busy),
        .done              (done),
        .err               (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rows; bit clr; int iaddr; int waddr;
        bit pv; int ps; bit av; int at;
        int dr;        // wfi cycles before data_rdy; -1 = never
        int stall;     // drop rdy for 3 cycles after this many reads; 0 = none
        int exp_rows; bit exp_err; bit exp_done; int exp_clr;
    } vec_t;

    typedef struct { bit w; int row; logic [127:0] pld; } wr_t;
    typedef struct { bit pv; int ps; bit av; int at; } fire_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int exp_rd[$];
    wr_t exp_wr[$];
    fire_t exp_fire[$];

    int rd_cnt, wr_cnt, fire_cnt, clr_cnt, wfi_cnt, done_cnt, err_cnt;
    int fire_cyc, err_cyc;
    bit err_clr;

    function automatic logic [127:0] mem(input int a);
        logic [31:0] x;
        x = 32'(a);
        return {x * 32'h9E37_79B1, ~x, 32'hC0DE_0000 | x, x * 32'h0100_0193 + 32'h1234};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Row buffer model: one-cycle read latency, junk when not reading.
    always @(posedge clk) begin
        buf_rd_data <= buf_rd_en ? mem(int'(buf_rd_addr)) : 128'($urandom);
    end

    // Monitor / scoreboard, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (buf_rd_en) begin
                rd_cnt++;
                chk("rd_only_when_rdy", top_lsu_rdy, 1'b1);
                if (exp_rd.size() == 0) begin
                    chk("unexpected_read", 1'b1, 1'b0);
                end else begin
                    chk("rd_addr", buf_rd_addr, exp_rd.pop_front());
                end
            end
            if ((lsu_top_iram_vld | lsu_top_wram_vld) != 16'd0) begin
                wr_cnt++;
                chk("one_ram_per_cycle", (lsu_top_iram_vld != 0) && (lsu_top_wram_vld != 0), 1'b0);
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", 1'b1, 1'b0);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    if (e.w) begin
                        chk("wram_vld", lsu_top_wram_vld, 16'd1 << e.row);
                        chk("wram_pld", lsu_top_wram_pld, e.pld);
                    end else begin
                        chk("iram_vld", lsu_top_iram_vld, 16'd1 << e.row);
                        chk("iram_pld", lsu_top_iram_pld, e.pld);
                    end
                end
            end
            if (lsu_top_vld) begin
                fire_cnt++;
                fire_cyc = cyc;
                if (exp_fire.size() == 0) begin
                    chk("unexpected_fire", 1'b1, 1'b0);
                end else begin
                    fire_t f;
                    f = exp_fire.pop_front();
                    chk("fire_pool", {lsu_top_pool_vld, lsu_top_pool_size}, {f.pv, 2'(f.ps)});
                    chk("fire_act", {lsu_top_act_vld, lsu_top_act_type}, {f.av, 2'(f.at)});
                end
            end else if ({lsu_top_pool_vld, lsu_top_pool_size, lsu_top_act_vld,
                          lsu_top_act_type} != 6'd0) begin
                chk("cfg_zero_outside_fire", 1'b1, 1'b0);
            end
            if (lsu_top_clr) clr_cnt++;
            if (lsu_top_wfi) wfi_cnt++;
            if (done) done_cnt++;
            if (err) begin
                err_cnt++;
                err_cyc = cyc;
                err_clr = lsu_top_clr;
            end
        end
    end

    task automatic clear_counts();
        rd_cnt = 0; wr_cnt = 0; fire_cnt = 0; clr_cnt = 0; wfi_cnt = 0;
        done_cnt = 0; err_cnt = 0; fire_cyc = -1; err_cyc = -1; err_clr = 1'b0;
    endtask

    task automatic push_expect(input vec_t v);
        for (int r = 0; r < v.exp_rows; r++) begin
            int ia, wa;
            ia = (v.iaddr + r) % (1 << AW);
            wa = (v.waddr + r) % (1 << AW);
            exp_rd.push_back(ia);
            exp_rd.push_back(wa);
            exp_wr.push_back('{w: 1'b0, row: r, pld: mem(ia)});
            exp_wr.push_back('{w: 1'b1, row: r, pld: mem(wa)});
        end
        if (v.exp_rows > 0) exp_fire.push_back('{pv: v.pv, ps: v.ps, av: v.av, at: v.at});
    endtask

    task automatic drive_cmd(input vec_t v, output int c0);
        @(posedge clk); #1;
        clear_counts();
        cmd_vld       = 1'b1;
        cmd_rows      = 5'(v.rows);
        cmd_clr       = v.clr;
        cmd_iaddr     = AW'(v.iaddr);
        cmd_waddr     = AW'(v.waddr);
        cmd_pool_vld  = v.pv;
        cmd_pool_size = 2'(v.ps);
        cmd_act_vld   = v.av;
        cmd_act_type  = 2'(v.at);
        top_lsu_rdy   = 1'b1;
        push_expect(v);
        @(posedge clk); #1;
        c0 = cyc;
        cmd_vld = 1'b0;
        // Scramble fields to prove they were registered.
        cmd_rows = 5'($urandom); cmd_clr = 1'($urandom);
        cmd_iaddr = AW'($urandom); cmd_waddr = AW'($urandom);
        cmd_pool_vld = 1'($urandom); cmd_pool_size = 2'($urandom);
        cmd_act_vld = 1'($urandom); cmd_act_type = 2'($urandom);
    endtask

    task automatic run_cmd(input vec_t v);
        int c0, exp_fc, stall_left;
        bit stalled, ended;
        stall_left = 0; stalled = 1'b0; ended = 1'b0;
        drive_cmd(v, c0);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk); #1;
            if (done_cnt + err_cnt > 0) begin
                ended = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (stall_left > 0) begin
                top_lsu_rdy = 1'b0;
                stall_left--;
            end else if (v.stall > 0 && !stalled && rd_cnt >= v.stall) begin
                top_lsu_rdy = 1'b0;
                stall_left = 2;
                stalled = 1'b1;
            end else begin
                top_lsu_rdy = 1'b1;
            end
            if (lsu_top_wfi) top_lsu_data_rdy = (v.dr >= 0) && (wfi_cnt >= v.dr);
            else top_lsu_data_rdy = 1'($urandom_range(0, 1));
        end
        chk("cmd_terminates", ended, 1'b1);
        @(posedge clk); #1;
        top_lsu_data_rdy = 1'b0;
        top_lsu_rdy = 1'b1;
        chk("cmd_rdy_after", cmd_rdy, 1'b1);
        chk("busy_after", busy, 1'b0);
        chk("done_cnt", done_cnt, v.exp_done);
        chk("err_cnt", err_cnt, v.exp_err);
        chk("clr_cnt", clr_cnt, v.exp_clr);
        chk("rows_written", wr_cnt, 2 * v.exp_rows);
        chk("fire_cnt", fire_cnt, (v.exp_rows > 0) ? 1 : 0);
        chk("queues_drained", exp_rd.size() + exp_wr.size() + exp_fire.size(), 0);
        if (v.exp_rows > 0) begin
            exp_fc = c0 + 2 * v.exp_rows + 1 + (v.clr ? 1 : 0) + ((v.stall > 0) ? 3 : 0);
            chk("fire_cycle", fire_cyc, exp_fc);
            chk("wfi_cycles", wfi_cnt, (v.dr >= 0) ? v.dr + 1 : TIMEOUT);
        end else begin
            chk("bad_err_next_cycle", err_cyc, c0);
            chk("bad_no_reads", rd_cnt, 0);
        end
        if (v.exp_err) chk("err_with_clr", err_clr, (v.exp_rows > 0) ? 1'b1 : 1'b0);
        exp_rd.delete(); exp_wr.delete(); exp_fire.delete();
    endtask

    vec_t vecs[8];

    initial begin
        vec_t rv;
        int c0;
        bit hit;
        //          rows clr iaddr  waddr  pv ps av at  dr stall  rows err done clr
        vecs[0] = '{4,  0, 'h010, 'h020, 0, 0, 0, 0,  5, 0,     4,  0,  1,   0};
        vecs[1] = '{16, 1, 'h100, 'h200, 1, 2, 1, 1,  0, 0,     16, 0,  1,   1};
        vecs[2] = '{0,  1, 'h055, 'h066, 1, 1, 1, 1,  0, 0,     0,  1,  0,   0};
        vecs[3] = '{20, 0, 'h3F0, 'h050, 0, 0, 0, 0,  2, 0,     16, 0,  1,   0};
        vecs[4] = '{2,  0, 'h3FF, 'h1FF, 0, 0, 1, 3,  1, 0,     2,  0,  1,   0};
        vecs[5] = '{6,  0, 'h040, 'h080, 0, 0, 1, 3,  3, 5,     6,  0,  1,   0};
        vecs[6] = '{3,  1, 'h0A0, 'h0B0, 1, 3, 1, 2, -1, 0,     3,  1,  0,   2};
        vecs[7] = '{31, 0, 'h200, 'h3F8, 1, 1, 0, 0,  1, 0,     16, 0,  1,   0};

        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_cmd_rdy", cmd_rdy, 1'b1);
        chk("reset_outputs_zero", {busy, done, err, buf_rd_en, lsu_top_vld, lsu_top_clr,
            lsu_top_wfi, lsu_top_iram_vld, lsu_top_wram_vld}, '0);

        for (int i = 0; i < 8; i++) run_cmd(vecs[i]);

        // Reset while row 5 is being loaded.
        rv = '{8, 0, 'h300, 'h310, 1, 1, 1, 1, 2, 0, 8, 0, 1, 0};
        drive_cmd(rv, c0);
        hit = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk); #1;
            if (rd_cnt >= 10) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reached_row5", hit, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_cmd_rdy", cmd_rdy, 1'b1);
        chk("midrst_outputs_zero", {busy, done, err, buf_rd_en, buf_rd_addr, lsu_top_vld,
            lsu_top_clr, lsu_top_wfi, lsu_top_iram_vld, lsu_top_wram_vld, lsu_top_pool_vld,
            lsu_top_pool_size, lsu_top_act_vld, lsu_top_act_type}, '0);
        chk("midrst_pld_zero", {lsu_top_iram_pld, lsu_top_wram_pld} != 256'd0, 1'b0);
        rst = 1'b0;
        exp_rd.delete(); exp_wr.delete(); exp_fire.delete();
        chk("midrst_no_done_err", done_cnt + err_cnt, 0);
        repeat (2) @(posedge clk);
        run_cmd(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mxu_cmd_seq.md
Name: mxu_cmd_seq

Overview:
Sequencer between the LSU command path and the MXU top. It accepts one matrix command at a time and loads up to 16 input rows and 16 weight rows from the local row buffer into the MXU. It then fires the MXU with pool/activation config, waits for result-ready and reports completion. It owns every lsu_top_* control/payload signal of the MXU top.

Parameters:
AW, 10, row-buffer address width (row granularity, 128-bit rows)
TIMEOUT, 4096, max cycles in WAIT before error abort (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cmd_vld  in  1  command valid
cmd_rdy  out  1  command ready (high only in IDLE)
cmd_rows  in  5  rows to load, 1..16
cmd_clr  in  1  clear MXU accumulators before load
cmd_iaddr  in  AW  input-row base address
cmd_waddr  in  AW  weight-row base address
cmd_pool_vld  in  1  pooling enable
cmd_pool_size  in  2  pool size code
cmd_act_vld  in  1  activation enable
cmd_act_type  in  2  activation type code
buf_rd_en  out  1  row-buffer read strobe
buf_rd_addr  out  AW  row-buffer read address
buf_rd_data  in  128  read data, valid exactly 1 cycle after buf_rd_en
lsu_top_vld  out  1  MXU fire pulse
lsu_top_clr  out  1  MXU clear pulse
lsu_top_iram_vld  out  16  one-hot input-row write select
lsu_top_iram_pld  out  128  input-row payload
lsu_top_wram_vld  out  16  one-hot weight-row write select
lsu_top_wram_pld  out  128  weight-row payload
lsu_top_pool_vld  out  1  pool enable, valid with lsu_top_vld
lsu_top_pool_size  out  2  pool size, valid with lsu_top_vld
lsu_top_act_vld  out  1  act enable, valid with lsu_top_vld
lsu_top_act_type  out  2  act type, valid with lsu_top_vld
lsu_top_wfi  out  1  high while waiting for MXU result
top_lsu_rdy  in  1  MXU can accept clr/row/fire
top_lsu_data_rdy  in  1  MXU result rows valid
busy  out  1  state != IDLE
done  out  1  1-cycle completion pulse
err  out  1  1-cycle error pulse (bad cmd or timeout)

Behaviour:
- Reset: state IDLE. All outputs 0, except cmd_rdy=1. Row/read counters and timeout counter cleared. Reset mid-command aborts with no done/err.
- Handshake: command captured on cmd_vld&&cmd_rdy, and all fields are registered. cmd_rdy=0 in every state except IDLE.
- Row count: cmd_rows=0 -> accept, err pulse next cycle, return IDLE, no MXU activity. cmd_rows 17..31 saturate to 16.
- States: IDLE -> (cmd_clr ? CLR : LOAD) -> LOAD -> FIRE -> WAIT -> DONE -> IDLE.
- CLR: lsu_top_clr=1 for the first cycle with top_lsu_rdy=1, then go to LOAD. Held off (clr=0) while rdy=0.
- LOAD read sequence: per row r (0..N-1), read iaddr+r, then waddr+r, on consecutive cycles. Total 2N reads.
- LOAD issue rule: a read issues only in a cycle where top_lsu_rdy=1. Addresses wrap modulo 2^AW.
- LOAD write-back: one cycle after an input read, lsu_top_iram_vld=1<<r and iram_pld=buf_rd_data. Same for weight reads on the wram_* pair. Only one of iram_vld/wram_vld is nonzero per cycle.
- LOAD in-flight data: a read already in flight is always written, even if rdy has since dropped. The MXU guarantees this one-cycle slack.
- LOAD exit: leave after the last wram write. Minimum LOAD length = 2N+1 cycles. Rows >= N are not written.
- FIRE: lsu_top_vld=1 for exactly one cycle, in the first cycle top_lsu_rdy=1. pool/act outputs show the registered cmd fields in that cycle and are 0 otherwise.
- WAIT: lsu_top_wfi=1. On top_lsu_data_rdy=1 go to DONE. If data_rdy is high in the cycle after FIRE, DONE follows immediately.
- WAIT timeout: counter starts at 0 on entry. Reaching TIMEOUT cycles without data_rdy -> err pulse, lsu_top_clr pulse in the same cycle, then IDLE.
- DONE: done=1 for one cycle, then IDLE. A new command may be accepted the following cycle.
- Ignored inputs: top_lsu_data_rdy outside WAIT is ignored. buf_rd_data is ignored except 1 cycle after buf_rd_en.

Test Plan:
- cmd_rows=4, cmd_clr=0, iaddr=0x10, waddr=0x20, rdy=1 -> reads 0x10,0x20,0x11,…,0x23. iram_vld 0x1,0x2,0x4,0x8 with matching pld. Then one lsu_top_vld pulse. data_rdy after 5 cycles -> done pulse, cmd_rdy back high.
- cmd_rows=16, cmd_clr=1, pool_vld=1 size=2, act_vld=1 type=1 -> one clr pulse first. 32 reads; last write iram/wram_vld=0x8000. Fire carries pool_size=2, act_type=1.
- Stall: rdy drops for 3 cycles mid-LOAD -> no new reads in those cycles. The in-flight row is still written, and the total row sequence is unchanged.
- Boundary: cmd_rows=0 -> err pulse, no buf_rd_en/lsu_top_* activity. cmd_rows=20 -> exactly 16 rows loaded. iaddr=2^AW-1, rows=2 -> second read address 0.
- Timeout: TIMEOUT=8, data_rdy never set -> wfi for 8 cycles, then err+clr pulse, IDLE, no done.
- Reset asserted during LOAD row 5 -> next cycle all outputs 0, cmd_rdy=1. A new command then completes normally.
